// File: rtl/adc_frame_builder.sv
`default_nettype none
// adc_frame_builder: offset-binary ADC stream -> signed decimated 16-bit words, framed with idle gaps.
// Rev 1.0
module adc_frame_builder #(
  parameter int FRAME_LEN  = 390,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  input  logic        enable,
  input  logic [1:0]  dec_sel,
  output logic        data_out_flag,
  output logic [15:0] data_out,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun
);

  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [8:0]     WORD_LAST = 9'(FRAME_LEN - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [1:0]     dec_q, dec_d;
  logic [15:0]    acc_q, acc_d;
  logic [2:0]     grp_q, grp_d;
  logic [8:0]     word_q, word_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [15:0]    dout_q, dout_d;
  logic           flag_q, flag_d;
  logic           fdone_q, fdone_d;
  logic           ovr_q, ovr_d;

  logic [15:0] sample_w;
  logic [15:0] sum_w;
  logic [2:0]  grp_max_w;

  // Offset-binary to two's complement is a bit-11 inversion, then sign-extend.
  assign sample_w = {{5{~adc_data[11]}}, adc_data[10:0]};
  assign sum_w    = acc_q + sample_w;

  always_comb begin
    grp_max_w = 3'd0;
    case (dec_q)
      2'd0:    grp_max_w = 3'd0;
      2'd1:    grp_max_w = 3'd1;
      2'd2:    grp_max_w = 3'd3;
      default: grp_max_w = 3'd7;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    word_d  = word_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;
    flag_d  = 1'b0;
    fdone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ACCUM;
          dec_d   = dec_sel;
          acc_d   = 16'h0000;
          grp_d   = 3'd0;
          word_d  = 9'd0;
          ovr_d   = 1'b0;
        end
      end

      S_ACCUM: begin
        if (adc_valid) begin
          if (grp_q == grp_max_w) begin
            dout_d = sum_w;
            flag_d = 1'b1;
            acc_d  = 16'h0000;
            grp_d  = 3'd0;
            if (word_q == WORD_LAST) begin
              fdone_d = 1'b1;
              word_d  = 9'd0;
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              word_d = word_q + 9'd1;
            end
          end else begin
            acc_d = sum_w;
            grp_d = grp_q + 3'd1;
          end
        end
      end

      S_GAP: begin
        if (adc_valid) begin
          ovr_d = 1'b1;
        end
        // The frame_done cycle is not counted, so the gap spans GAP_CYCLES full
        // idle cycles after it plus the re-entry cycle.
        if (gap_q == GAP_LAST) begin
          if (enable) begin
            state_d = S_ACCUM;
            dec_d   = dec_sel;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dec_q   <= 2'd0;
      acc_q   <= 16'h0000;
      grp_q   <= 3'd0;
      word_q  <= 9'd0;
      gap_q   <= '0;
      dout_q  <= 16'h0000;
      flag_q  <= 1'b0;
      fdone_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      flag_q  <= flag_d;
      fdone_q <= fdone_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out_flag = flag_q;
  assign data_out      = dout_q;
  assign frame_done    = fdone_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_builder.sv
`default_nettype none
// tb_adc_frame_builder: table vectors plus scoreboard checking of adc_frame_builder.
// Rev 1.0
module tb_adc_frame_builder;

  localparam int FRAME_LEN  = 390;
  localparam int GAP_CYCLES = 4;

  logic        clk_25m = 1'b0;
  logic        rst_n;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        enable;
  logic [1:0]  dec_sel;
  logic        data_out_flag;
  logic [15:0] data_out;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  adc_frame_builder #(.FRAME_LEN(FRAME_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_25m       (clk_25m),
    .rst_n         (rst_n),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .enable        (enable),
    .dec_sel       (dec_sel),
    .data_out_flag (data_out_flag),
    .data_out      (data_out),
    .frame_done    (frame_done),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #20 clk_25m = ~clk_25m;

  typedef struct {
    logic [15:0] d;
    bit          last;
    int          cyc;
  } sb_t;

  typedef struct {
    logic [1:0]  dec;
    logic [11:0] val;
    logic [15:0] exp;
  } vec_t;

  sb_t         sbq[$];
  sb_t         mon_e;
  vec_t        vt[8];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          nflags = 0;
  int          fd_cyc = 0;
  bit          fd_seen = 0;
  logic [15:0] exp_hold = 16'h0000;

  always @(posedge clk_25m) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Scoreboard side: every flag must match the oldest expected word, its frame_done and its cycle.
  always @(negedge clk_25m) begin
    if (rst_n) begin
      if (data_out_flag) begin
        nflags++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_flag: actual data_out %0h with no expected word", data_out);
        end else begin
          mon_e = sbq.pop_front();
          chk("data_out", {16'h0, data_out}, {16'h0, mon_e.d});
          chk("frame_done", {31'h0, frame_done}, {31'h0, mon_e.last});
          chk("flag_latency", cyc_cnt, mon_e.cyc);
        end
        if (fd_seen) begin
          chk("gap_spacing", {31'h0, (cyc_cnt - fd_cyc) >= GAP_CYCLES + 2}, 32'h1);
          fd_seen = 0;
        end
        if (frame_done) begin
          fd_seen = 1;
          fd_cyc  = cyc_cnt;
        end
      end else if (frame_done) begin
        chk("frame_done_without_flag", {31'h0, frame_done}, 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic feed(input logic [11:0] v, input bit push, input logic [15:0] e, input bit last);
    sb_t s;
    adc_valid = 1'b1;
    adc_data  = v;
    if (push) begin
      s.d    = e;
      s.last = last;
      s.cyc  = cyc_cnt + 1;
      sbq.push_back(s);
    end
    cyc();
    adc_valid = 1'b0;
    adc_data  = 12'($urandom);
  endtask

  // An adc_valid in the IDLE->ACCUM entry cycle must be ignored.
  task automatic start_frame(input logic [1:0] dec);
    dec_sel   = dec;
    enable    = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 12'h123;
    cyc();
    adc_valid = 1'b0;
    chk("busy_after_entry", {31'h0, busy}, 32'h1);
    chk("overrun_cleared", {31'h0, overrun}, 32'h0);
  endtask

  task automatic run_words(input int dec, input int nwords, input int fixed_words,
                           input logic [11:0] fixed_val, input logic [15:0] fixed_exp,
                           input bit dense, input int sw_word, input logic [1:0] sw_dec,
                           input int drop_word);
    int n;
    int sum;
    logic [11:0] v;
    n = 1 << dec;
    for (int w = 0; w < nwords; w++) begin
      if (w == sw_word) dec_sel = sw_dec;
      if (w == drop_word) enable = 1'b0;
      sum = 0;
      for (int g = 0; g < n; g++) begin
        v = (w < fixed_words) ? fixed_val : 12'($urandom_range(0, 4095));
        sum += int'(v) - 2048;
        if (!dense && $urandom_range(0, 3) == 0) cyc();
        feed(v, g == n - 1, (w < fixed_words) ? fixed_exp : sum[15:0], w == FRAME_LEN - 1);
      end
      exp_hold = (w < fixed_words) ? fixed_exp : sum[15:0];
    end
  endtask

  task automatic finish_gap(input bit keep);
    if (!keep) enable = 1'b0;
    repeat (GAP_CYCLES + 2) cyc();
    chk("frame_drained", sbq.size(), 32'h0);
    chk("busy_after_gap", {31'h0, busy}, {31'h0, keep});
    chk("data_out_hold", {16'h0, data_out}, {16'h0, exp_hold});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    vt[0] = '{2'd0, 12'hFFF, 16'h07FF};
    vt[1] = '{2'd0, 12'h000, 16'hF800};
    vt[2] = '{2'd1, 12'h000, 16'hF000};
    vt[3] = '{2'd2, 12'hFFF, 16'h1FFC};
    vt[4] = '{2'd3, 12'h000, 16'hC000};
    vt[5] = '{2'd3, 12'hFFF, 16'h3FF8};
    vt[6] = '{2'd1, 12'h801, 16'h0002};
    vt[7] = '{2'd2, 12'h7FF, 16'hFFFC};

    rst_n     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = 12'h000;
    enable    = 1'b0;
    dec_sel   = 2'd0;
    repeat (3) cyc();
    chk("rst_flag", {31'h0, data_out_flag}, 32'h0);
    chk("rst_data", {16'h0, data_out}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;

    // Idle with enable low: strobes must do nothing.
    for (int i = 0; i < 20; i++) begin
      adc_valid = i[0];
      adc_data  = 12'($urandom);
      cyc();
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end
    adc_valid = 1'b0;
    chk("idle_flags", nflags, 32'h0);
    chk("idle_data", {16'h0, data_out}, 32'h0);

    // N=1 constant full-scale, dense; strobes continue into the gap.
    f0 = nflags;
    start_frame(2'd0);
    run_words(0, FRAME_LEN, FRAME_LEN, 12'hFFF, 16'h07FF, 1, -1, 2'd0, -1);
    adc_valid = 1'b1;
    adc_data  = 12'hFFF;
    repeat (3) cyc();
    adc_valid = 1'b0;
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    finish_gap(0);
    chk("overrun_sticky_idle", {31'h0, overrun}, 32'h1);
    chk("n1_flag_count", nflags - f0, FRAME_LEN);

    // Table: first word of each frame from the vector, remainder random.
    for (int i = 0; i < 8; i++) begin
      f0 = nflags;
      start_frame(vt[i].dec);
      run_words(int'(vt[i].dec), FRAME_LEN, 1, vt[i].val, vt[i].exp, 0, -1, 2'd0, -1);
      finish_gap(0);
      chk("vec_flag_count", nflags - f0, FRAME_LEN);
    end

    // dec_sel 2->0 at word 100: this frame stays N=4, next frame N=1.
    f0 = nflags;
    start_frame(2'd2);
    run_words(2, FRAME_LEN, 0, 12'h0, 16'h0, 0, 100, 2'd0, -1);
    finish_gap(1);
    run_words(0, FRAME_LEN, 0, 12'h0, 16'h0, 0, -1, 2'd0, -1);
    finish_gap(0);
    chk("dec_change_flag_count", nflags - f0, 2 * FRAME_LEN);

    // enable dropped at word 200: frame still completes.
    f0 = nflags;
    start_frame(2'd1);
    run_words(1, FRAME_LEN, 0, 12'h0, 16'h0, 0, -1, 2'd0, 200);
    finish_gap(0);
    chk("drop_flag_count", nflags - f0, FRAME_LEN);

    // Async reset at word 50, mid-group.
    start_frame(2'd1);
    run_words(1, 50, 0, 12'h0, 16'h0, 1, -1, 2'd0, -1);
    feed(12'hABC, 0, 16'h0, 0);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_data", {16'h0, data_out}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_flag", {31'h0, data_out_flag}, 32'h0);
    chk("arst_drained", sbq.size(), 32'h0);
    enable = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    f0 = nflags;
    start_frame(2'd0);
    run_words(0, FRAME_LEN, 0, 12'h0, 16'h0, 0, -1, 2'd0, -1);
    finish_gap(0);
    chk("arst_restart_flag_count", nflags - f0, FRAME_LEN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_builder.md
# adc_frame_builder

Upstream stage of the ARM ping-pong read buffer. Converts the raw 12-bit offset-binary ADC stream into signed 16-bit decimated samples, groups them into fixed frames of FRAME_LEN words, and emits one `data_out_flag` pulse per word. Inter-frame idle gaps are guaranteed so the ping-pong writer can swap banks without losing a word.

## Interface
- FRAME_LEN, 390, words per frame; must equal the buffer's per-bank count.
- GAP_CYCLES, 4, idle cycles forced after each frame's last word; minimum 2.
- clk_25m  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- adc_valid  in  1  one-cycle strobe, `adc_data` valid.
- adc_data  in  12  offset-binary sample (0x800 = zero).
- enable  in  1  level; high = produce frames.
- dec_sel  in  2  decimation N = 2^dec_sel (1, 2, 4, 8).
- data_out_flag  out  1  one-cycle pulse, `data_out` valid.
- data_out  out  16  signed two's-complement decimated word.
- frame_done  out  1  one-cycle pulse coincident with the frame's last `data_out_flag`.
- busy  out  1  high in ACCUM and GAP.
- overrun  out  1  sticky; set on `adc_valid` in GAP, cleared only on IDLE→ACCUM.

## Operation
- States:
  - IDLE: wait for `enable`. On `enable`=1, latch `dec_sel` into `dec_q`, clear the accumulator, group and word counters and `overrun`, then go to ACCUM.
  - ACCUM: on `adc_valid`, add s = `adc_data` − 2048 (signed 12-bit, bit-11 inversion) to the signed 16-bit accumulator.
    - On the N-th sample of a group: register the group sum to `data_out`, pulse `data_out_flag`, clear the accumulator for the next group, increment `word_cnt`.
    - When `word_cnt` reaches FRAME_LEN: pulse `frame_done` with that flag, go to GAP.
  - GAP: count GAP_CYCLES cycles. Every `adc_valid` is dropped and sets `overrun`. At the end, go to ACCUM if `enable`=1, else IDLE. `dec_q` is re-latched from `dec_sel` on entry to ACCUM.
- Arithmetic:
  - The output is the group sum, not divided by N.
  - Range is −16384..+16376, so the result is always representable. There is no saturation logic and no overflow is possible.
  - N=1 gives the sign-extended sample.
- `dec_sel` changes mid-frame are ignored until the next frame.
- `enable` falling mid-frame: the current frame completes to FRAME_LEN words, then GAP, then IDLE. Partial frames are never emitted.
- Reset mid-frame: all state clears immediately. The partial frame is discarded and no flag is emitted.
- `word_cnt` counts 0..FRAME_LEN−1 (9 bits). `grp_cnt` counts 0..7 (3 bits). Both wrap to 0 at frame or group end.

## Timing
- Reset values:
  - `data_out_flag`=0, `data_out`=16'h0000, `frame_done`=0, `busy`=0, `overrun`=0, state=IDLE.
- Latency: the `adc_valid` completing a group at cycle t gives `data_out_flag`=1 at t+1.
- `data_out` is registered and holds its value until the next flag.
- Flags are never back-to-back unless `adc_valid` is back-to-back with N=1.
- IDLE→ACCUM takes 1 cycle. An `adc_valid` in the entry cycle is ignored.
- After `frame_done`, at least GAP_CYCLES+1 cycles pass with no `data_out_flag`. This satisfies the buffer's bank-swap cycle.
- `busy` rises the cycle after `enable` is sampled high in IDLE. It falls the cycle the GAP→IDLE transition occurs.

## Test plan
- Reset/idle:
  - Stimulus: `enable`=0 with `adc_valid` toggling.
  - Required: no flags, `busy`=0, all outputs at reset values.
- N=1, constant input:
  - Stimulus: `adc_data`=0xFFF every cycle.
  - Required: 390 flags with `data_out`=0x07FF. `frame_done` on the 390th flag. Then ≥5 cycles with no flag, and `overrun`=1 because input continued during GAP.
- N=8, extremes:
  - Stimulus: 8 samples of 0x000.
  - Required: `data_out`=0xC000 (−16384). Then 8 samples of 0xFFF give `data_out`=0x3FF8 (+16376). Flag occurs 1 cycle after the 8th `adc_valid`.
- `dec_sel` change mid-frame:
  - Stimulus: switch `dec_sel` 2→0 at word 100.
  - Required: rest of the frame still sums 4 samples per word. The next frame uses N=1.
- `enable` drop mid-frame:
  - Stimulus: drop `enable` at word 200 while feeding samples.
  - Required: exactly 390 words total, `frame_done`, GAP, then IDLE with `busy`=0.
- Async reset at word 50:
  - Required: outputs clear immediately. After release with `enable`=1, the next frame restarts at word 0 and yields exactly 390 flags.
